module_add_scheduler: RTL and testbench
=======================================

MODULE_ADD_SCHEDULER -- requirements
Module: module_add_scheduler

Interface
REQ-001 SHALL have parameter: SAT_LIMIT, 100, signed 32-bit upper clamp applied to every sum.
REQ-002 SHALL have port: clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port: in_req_valid  input  2  bit i = requester i presents operands.
REQ-005 SHALL have ports: in_a0, in_b0, in_a1, in_b1  input  32  signed operands of requesters 0 and 1.
REQ-006 SHALL have port: out_req_ready  output  2  one-hot acceptance strobe to requester.
REQ-007 SHALL have port: out_valid  output  1  result available.
REQ-008 SHALL have port: in_ready  input  1  consumer accepts result.
REQ-009 SHALL have port: out_add_result  output  32  signed clamped sum.
REQ-010 SHALL have port: out_is_even  output  1  1 when out_add_result is even.
REQ-011 SHALL have port: out_grant_id  output  1  requester that owns the current result.
REQ-012 SHALL have port: out_busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> ADD -> CHECK -> RESP -> IDLE, one shared adder/parity datapath.
REQ-014 In IDLE with any in_req_valid set, SHALL grant one requester, assert its out_req_ready bit that same cycle (combinational), capture its operands, and move to ADD.
REQ-015 Both valid: SHALL grant the requester not granted last; pointer updates only on result handshake; after reset requester 0 wins first.
REQ-016 out_req_ready SHALL be 0 outside IDLE; a request is accepted only when valid and ready coincide.
REQ-017 ADD SHALL register sum = a + b modulo 2^32 (signed wrap, no overflow detect), then result = SAT_LIMIT if sum > SAT_LIMIT (signed compare), else sum; no lower clamp.
REQ-018 CHECK SHALL register out_is_even = ~result[0] (negative values included).
REQ-019 RESP SHALL hold out_valid=1 and stable out_add_result, out_is_even, out_grant_id until in_ready=1; handshake cycle returns to IDLE.
REQ-020 Latency: request accepted at edge N SHALL give out_valid high from cycle N+3; minimum 4 cycles per transaction; no new acceptance in the handshake cycle.
REQ-021 in_ready while out_valid=0 SHALL be ignored.
REQ-022 Requester dropping in_req_valid before grant SHALL lose nothing and cause no state change.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, out_valid=0, out_req_ready=0, out_add_result=0, out_is_even=0, out_grant_id=0, out_busy=0, pointer to "last granted = 1".
REQ-024 Reset mid-transaction SHALL discard the in-flight result; no out_valid after release until a new request.
REQ-025 First grant SHALL be possible in the first cycle after rst_n deasserts.

Configuration
REQ-026 With SCHED_SAT_COUNT_EN defined, SHALL add port out_sat_count  output  16, counting handshaken results that were clamped, saturating at 0xFFFF, reset to 0.
REQ-027 Without SCHED_SAT_COUNT_EN, port and counter SHALL be absent; all other behaviour identical.

Verification
REQ-028 Req0 a=10,b=20, in_ready=1 -> out_valid at N+3, result 30, even 1, grant_id 0.
REQ-029 Req1 a=60,b=61 -> result 100, even 1; with macro out_sat_count 0->1.
REQ-030 Both valid continuously, in_ready=1 -> grants alternate 0,1,0,1; one result per 4 cycles.
REQ-031 a=-7,b=2 -> result -5, even 0; a=0x7FFFFFFF,b=1 -> result 0x80000000 (not clamped), even 1.
REQ-032 in_ready=0 for 5 cycles in RESP -> outputs stable, out_req_ready=0, no second grant until handshake.
REQ-033 rst_n low during CHECK -> outputs zero at once; after release no out_valid without new request.

Source files
------------

// File: rtl/module_add_scheduler.sv
// Two-requester add/clamp/parity scheduler sharing one datapath (IDLE->ADD->CHECK->RESP).
// Optional SCHED_SAT_COUNT_EN adds out_sat_count, a saturating count of clamped, handshaken results.
module module_add_scheduler #(
  parameter int SAT_LIMIT = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  in_req_valid,
  input  logic [31:0] in_a0,
  input  logic [31:0] in_b0,
  input  logic [31:0] in_a1,
  input  logic [31:0] in_b1,
  output logic [1:0]  out_req_ready,
  output logic        out_valid,
  input  logic        in_ready,
  output logic [31:0] out_add_result,
  output logic        out_is_even,
  output logic        out_grant_id,
  output logic        out_busy
`ifdef SCHED_SAT_COUNT_EN
  ,
  output logic [15:0] out_sat_count
`endif
);

  typedef enum logic [1:0] {IDLE, ADD, CHECK, RESP} state_t;

  state_t      r_state;
  logic        r_last;
  logic        r_valid;
  logic        r_is_even;
  logic        r_grant_id;
  logic        r_busy;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [31:0] r_result;

  logic        w_grant;
  logic        w_accept;
  logic [31:0] w_sum;
  logic        w_clamp_hit;
  logic [31:0] w_clamped;

  // Round-robin only matters on contention; a lone requester always wins.
  assign w_grant       = (in_req_valid == 2'b11) ? ~r_last : in_req_valid[1];
  assign w_accept      = rst_n && (r_state == IDLE) && (in_req_valid != 2'b00);
  assign out_req_ready = w_accept ? (w_grant ? 2'b10 : 2'b01) : 2'b00;

  assign w_sum       = r_a + r_b;
  assign w_clamp_hit = $signed(w_sum) > SAT_LIMIT;
  assign w_clamped   = w_clamp_hit ? 32'(SAT_LIMIT) : w_sum;

  assign out_valid      = r_valid;
  assign out_add_result = r_result;
  assign out_is_even    = r_is_even;
  assign out_grant_id   = r_grant_id;
  assign out_busy       = r_busy;

`ifdef SCHED_SAT_COUNT_EN
  logic        r_sat_hit;
  logic [15:0] r_sat_count;
  assign out_sat_count = r_sat_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sat_hit   <= 1'b0;
      r_sat_count <= 16'd0;
    end else begin
      if (r_state == ADD) begin
        r_sat_hit <= w_clamp_hit;
      end
      if (r_state == RESP && in_ready && r_sat_hit && r_sat_count != 16'hFFFF) begin
        r_sat_count <= r_sat_count + 16'd1;
      end
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= 1'b1;
      r_valid    <= 1'b0;
      r_is_even  <= 1'b0;
      r_grant_id <= 1'b0;
      r_busy     <= 1'b0;
      r_a        <= 32'd0;
      r_b        <= 32'd0;
      r_result   <= 32'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_a        <= w_grant ? in_a1 : in_a0;
            r_b        <= w_grant ? in_b1 : in_b0;
            r_grant_id <= w_grant;
            r_busy     <= 1'b1;
            r_state    <= ADD;
          end
        end
        ADD: begin
          r_result <= w_clamped;
          r_state  <= CHECK;
        end
        CHECK: begin
          r_is_even <= ~r_result[0];
          r_valid   <= 1'b1;
          r_state   <= RESP;
        end
        RESP: begin
          // Arbitration pointer advances only once the consumer has the result.
          if (in_ready) begin
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_last  <= r_grant_id;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_module_add_scheduler.sv
// Scoreboard bench for module_add_scheduler: arbitration, latency, clamp/parity, hold and reset.
module tb_module_add_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_req_valid = 2'b00;
  logic [31:0] in_a0 = '0, in_b0 = '0, in_a1 = '0, in_b1 = '0;
  logic [1:0]  out_req_ready;
  logic        out_valid;
  logic        in_ready = 1'b1;
  logic [31:0] out_add_result;
  logic        out_is_even;
  logic        out_grant_id;
  logic        out_busy;
`ifdef SCHED_SAT_COUNT_EN
  logic [15:0] out_sat_count;
  int          exp_sat = 0;
`endif

  module_add_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_req_valid   (in_req_valid),
    .in_a0          (in_a0),
    .in_b0          (in_b0),
    .in_a1          (in_a1),
    .in_b1          (in_b1),
    .out_req_ready  (out_req_ready),
    .out_valid      (out_valid),
    .in_ready       (in_ready),
    .out_add_result (out_add_result),
    .out_is_even    (out_is_even),
    .out_grant_id   (out_grant_id),
    .out_busy       (out_busy)
`ifdef SCHED_SAT_COUNT_EN
    ,
    .out_sat_count  (out_sat_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        even;
    logic        id;
    logic        clamp;
    int          t;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_tmp;
  int          n_checks = 0;
  int          n_fail = 0;
  int          n_accept = 0;
  int          cyc = 0;
  logic        m_busy = 1'b0;
  logic        last_model = 1'b1;
  logic        prev_valid = 1'b0;
  logic        mon_g;
  logic [1:0]  mon_rdy;
  logic [31:0] mon_a, mon_b, mon_s;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: arbitration, result prediction and handshake tracking.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      sb.delete();
      m_busy     = 1'b0;
      last_model = 1'b1;
`ifdef SCHED_SAT_COUNT_EN
      exp_sat = 0;
      check("rst_sat_count", out_sat_count, 0);
`endif
      check("rst_valid", out_valid, 0);
      check("rst_ready", out_req_ready, 0);
      check("rst_result", out_add_result, 0);
      check("rst_even", out_is_even, 0);
      check("rst_grant", out_grant_id, 0);
      check("rst_busy", out_busy, 0);
    end else begin
      mon_g   = (in_req_valid == 2'b11) ? ~last_model : in_req_valid[1];
      mon_rdy = (!m_busy && in_req_valid != 2'b00) ? (mon_g ? 2'b10 : 2'b01) : 2'b00;
      check("req_ready", out_req_ready, mon_rdy);
      check("busy", out_busy, m_busy);
      if (out_valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", out_valid, 0);
        end else begin
          if (!prev_valid) check("latency", cyc - sb[0].t, 3);
          check("result", out_add_result, sb[0].res);
          check("even", out_is_even, sb[0].even);
          check("grant_id", out_grant_id, sb[0].id);
          if (in_ready) begin
            last_model = sb[0].id;
`ifdef SCHED_SAT_COUNT_EN
            if (sb[0].clamp && exp_sat < 16'hFFFF) exp_sat++;
`endif
            void'(sb.pop_front());
            m_busy = 1'b0;
          end
        end
      end
      if (mon_rdy != 2'b00) begin
        mon_a = mon_g ? in_a1 : in_a0;
        mon_b = mon_g ? in_b1 : in_b0;
        mon_s = mon_a + mon_b;
        e_tmp.clamp = $signed(mon_s) > 32'sd100;
        e_tmp.res   = e_tmp.clamp ? 32'd100 : mon_s;
        e_tmp.even  = ~e_tmp.res[0];
        e_tmp.id    = mon_g;
        e_tmp.t     = cyc;
        sb.push_back(e_tmp);
        m_busy = 1'b1;
        n_accept++;
      end
`ifdef SCHED_SAT_COUNT_EN
      check("sat_count", out_sat_count, exp_sat);
`endif
    end
    prev_valid = out_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_accept(input int target);
    int k = 0;
    while (n_accept < target && k < 50) begin
      tick();
      k++;
    end
    check("accept_timeout", n_accept, target);
  endtask

  task automatic wait_drain();
    int k = 0;
    while ((sb.size() != 0 || m_busy) && k < 100) begin
      tick();
      k++;
    end
    check("drain_timeout", sb.size(), 0);
  endtask

  task automatic do_req(input logic id, input logic [31:0] a, input logic [31:0] b);
    int target;
    target = n_accept + 1;
    if (id) begin
      in_a1 = a; in_b1 = b;
    end else begin
      in_a0 = a; in_b0 = b;
    end
    in_req_valid[id] = 1'b1;
    wait_accept(target);
    in_req_valid[id] = 1'b0;
  endtask

  initial begin
    int t0;
    int base;
    int seen;
    int k;

    repeat (3) tick();
    rst_n = 1'b1;

    // Basic transactions, including clamp, negative and wrap cases.
    do_req(1'b0, 32'd10, 32'd20);
    wait_drain();
    do_req(1'b1, 32'd60, 32'd61);
    wait_drain();
    do_req(1'b0, -32'sd7, 32'd2);
    wait_drain();
    do_req(1'b0, 32'h7FFF_FFFF, 32'd1);
    wait_drain();
    do_req(1'b1, 32'd40, 32'd60);
    wait_drain();

    // Contention: alternating grants, one result every four cycles.
    in_a0 = $urandom; in_b0 = $urandom;
    in_a1 = $urandom_range(0, 50); in_b1 = $urandom_range(0, 49);
    base = n_accept;
    in_req_valid = 2'b11;
    wait_accept(base + 1);
    t0 = cyc;
    wait_accept(base + 9);
    check("throughput_cycles", cyc - t0, 32);
    in_req_valid = 2'b00;
    wait_drain();

    // Consumer stall: outputs held, no new grant until handshake.
    in_ready = 1'b0;
    do_req(1'b0, 32'd5, 32'd6);
    in_a1 = 32'd1; in_b1 = 32'd2;
    in_req_valid[1] = 1'b1;
    k = 0;
    while (!out_valid && k < 20) begin
      tick();
      k++;
    end
    check("stall_valid_seen", out_valid, 1);
    repeat (5) begin
      tick();
      check("stall_ready", out_req_ready, 0);
      check("stall_result", out_add_result, 32'd11);
    end
    base = n_accept;
    in_ready = 1'b1;
    wait_accept(base + 1);
    in_req_valid = 2'b00;
    wait_drain();

    // Reset in CHECK discards the in-flight result.
    do_req(1'b1, 32'd3, 32'd4);
    tick();
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_result", out_add_result, 0);
    check("async_grant", out_grant_id, 0);
    check("async_busy", out_busy, 0);
    check("async_ready", out_req_ready, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (10) begin
      tick();
      seen = seen | int'(out_valid);
    end
    check("post_reset_valid", seen, 0);
    do_req(1'b0, 32'd8, 32'd8);
    wait_drain();

    repeat (2) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
